// File: rtl/down_count_timer_pkg.sv
// Shared types for the loadable down-count timer: FSM state encoding.
package down_count_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } dct_state_t;

endpackage

// File: rtl/down_count_timer_if.sv
// Command, enable/abort and completion signals of the down-count timer.
interface down_count_timer_if #(
   parameter int WIDTH = 3
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_count;
   logic             en;
   logic             abort;
   logic [WIDTH-1:0] Q;
   logic             busy;
   logic             y;
   logic             done_valid;
   logic             done_ready;
   logic             done_aborted;

   // The controller side issues commands and consumes completions.
   modport master (
      output cmd_valid, cmd_count, en, abort, done_ready,
      input  cmd_ready, Q, busy, y, done_valid, done_aborted
   );

   modport slave (
      input  cmd_valid, cmd_count, en, abort, done_ready,
      output cmd_ready, Q, busy, y, done_valid, done_aborted
   );

endinterface

// File: rtl/down_count_timer_core.sv
// Count register with load, saturating decrement and zero/one detect.
module dct_core #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] q,
   output logic             is_zero,
   output logic             is_one
);

   assign is_zero = (q == '0);
   assign is_one  = (q == WIDTH'(1));

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= load_value;
      end else if (dec && !is_zero) begin
         q <= q - WIDTH'(1);
      end
   end

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-count timer: command handshake in, count down while enabled,
// completion (normal or aborted) reported through a done handshake.
module down_count_timer
   import down_count_pkg::*;
#(
   parameter int WIDTH       = 3,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input logic               clk,
   input logic               reset,
   down_count_timer_if.slave bus
);

   dct_state_t       state;
   logic [WIDTH-1:0] reload;
   logic             y_r;
   logic             done_valid_r;
   logic             done_aborted_r;

   logic             cmd_fire;
   logic             core_load;
   logic             core_dec;
   logic [WIDTH-1:0] core_load_value;
   logic [WIDTH-1:0] q;
   logic             is_zero;
   logic             is_one;

   assign cmd_fire = (state == IDLE) && bus.cmd_valid;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      core_load       = 1'b0;
      core_dec        = 1'b0;
      core_load_value = bus.cmd_count;
      case (state)
         IDLE: core_load = cmd_fire;
         RUN:  core_dec  = bus.en && !bus.abort;
         HOLD: begin
            if (bus.done_ready && AUTO_RELOAD && !done_aborted_r) begin
               core_load       = 1'b1;
               core_load_value = reload;
            end
         end
         default: ;
      endcase
   end

   dct_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk        (clk),
      .reset      (reset),
      .load       (core_load),
      .dec        (core_dec),
      .load_value (core_load_value),
      .q          (q),
      .is_zero    (is_zero),
      .is_one     (is_one)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         reload         <= '0;
         y_r            <= 1'b0;
         done_valid_r   <= 1'b0;
         done_aborted_r <= 1'b0;
      end else begin
         y_r <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_fire) begin
                  reload <= bus.cmd_count;
                  if (bus.cmd_count == '0) begin
                     // Zero-length run completes immediately.
                     state          <= HOLD;
                     y_r            <= 1'b1;
                     done_valid_r   <= 1'b1;
                     done_aborted_r <= 1'b0;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               // Abort has priority over the final decrement.
               if (bus.abort) begin
                  state          <= HOLD;
                  done_valid_r   <= 1'b1;
                  done_aborted_r <= 1'b1;
               end else if (bus.en && (is_one || is_zero)) begin
                  state        <= HOLD;
                  y_r          <= 1'b1;
                  done_valid_r <= 1'b1;
               end
            end
            HOLD: begin
               if (bus.done_ready) begin
                  done_valid_r   <= 1'b0;
                  done_aborted_r <= 1'b0;
                  if (AUTO_RELOAD && !done_aborted_r) begin
                     if (reload == '0) begin
                        state        <= HOLD;
                        y_r          <= 1'b1;
                        done_valid_r <= 1'b1;
                     end else begin
                        state <= RUN;
                     end
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready    = (state == IDLE);
   assign bus.busy         = (state == RUN) || (state == HOLD);
   assign bus.Q            = q;
   assign bus.y            = y_r;
   assign bus.done_valid   = done_valid_r;
   assign bus.done_aborted = done_aborted_r;

endmodule

// File: tb/tb_down_count_timer.sv
// Drives a one-shot and an auto-reload timer with identical stimulus and
// compares both against a transaction-level reference model every cycle.
module tb_down_count_timer;

   localparam int WIDTH = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   down_count_timer_if #(.WIDTH(WIDTH)) bus0 ();
   down_count_timer_if #(.WIDTH(WIDTH)) bus1 ();

   down_count_timer #(.WIDTH(WIDTH), .AUTO_RELOAD(1'b0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   down_count_timer #(.WIDTH(WIDTH), .AUTO_RELOAD(1'b1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   logic       s_cv, s_en, s_ab, s_dr;
   logic [2:0] s_cnt;

   // Reference model: one record per timer (index 1 is the auto-reload one).
   int m_q[2];
   int m_rel[2];
   bit m_run[2], m_hold[2], m_abt[2], m_y[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_q[k] = 0; m_rel[k] = 0;
         m_run[k] = 0; m_hold[k] = 0; m_abt[k] = 0; m_y[k] = 0;
      end
   endtask

   task automatic start_run(input int k, input int n);
      m_q[k] = n;
      if (n == 0) begin
         m_hold[k] = 1; m_y[k] = 1;
      end else begin
         m_run[k] = 1;
      end
   endtask

   task automatic model_step(input int k);
      bit was_aborted;
      m_y[k] = 0;
      if (m_hold[k]) begin
         if (s_dr) begin
            m_hold[k]   = 0;
            was_aborted = m_abt[k];
            m_abt[k]    = 0;
            if (k == 1 && !was_aborted) start_run(k, m_rel[k]);
         end
      end else if (m_run[k]) begin
         if (s_ab) begin
            m_run[k] = 0; m_hold[k] = 1; m_abt[k] = 1;
         end else if (s_en) begin
            m_q[k] = m_q[k] - 1;
            if (m_q[k] == 0) begin
               m_run[k] = 0; m_hold[k] = 1; m_y[k] = 1;
            end
         end
      end else if (s_cv) begin
         m_rel[k] = s_cnt;
         start_run(k, s_cnt);
      end
   endtask

   function automatic logic [7:0] obs(input int k);
      if (k == 0)
         return {bus0.cmd_ready, bus0.busy, bus0.y, bus0.done_valid, bus0.done_aborted, bus0.Q};
      return {bus1.cmd_ready, bus1.busy, bus1.y, bus1.done_valid, bus1.done_aborted, bus1.Q};
   endfunction

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         logic [7:0] o;
         o = obs(k);
         check($sformatf("d%0d_cmd_ready", k), o[7], !(m_run[k] || m_hold[k]));
         check($sformatf("d%0d_busy", k), o[6], m_run[k] || m_hold[k]);
         check($sformatf("d%0d_y", k), o[5], m_y[k]);
         check($sformatf("d%0d_done_valid", k), o[4], m_hold[k]);
         check($sformatf("d%0d_done_aborted", k), o[3], m_abt[k]);
         check($sformatf("d%0d_Q", k), o[2:0], m_q[k]);
      end
   endtask

   task automatic drive();
      bus0.cmd_valid = s_cv; bus0.cmd_count = s_cnt; bus0.en = s_en;
      bus0.abort = s_ab; bus0.done_ready = s_dr;
      bus1.cmd_valid = s_cv; bus1.cmd_count = s_cnt; bus1.en = s_en;
      bus1.abort = s_ab; bus1.done_ready = s_dr;
   endtask

   // One clock: check outputs mid-cycle, apply inputs, advance the model.
   task automatic cycle(input logic cv, input int cnt, input logic e,
                        input logic ab, input logic dr);
      @(negedge clk);
      check_all();
      s_cv = cv; s_cnt = 3'(cnt); s_en = e; s_ab = ab; s_dr = dr;
      drive();
      @(posedge clk);
      model_step(0);
      model_step(1);
   endtask

   // Called right after a rising edge; completes before the falling edge.
   task automatic apply_reset();
      #1 reset = 1'b1;
      #1;
      check("rst_q0", bus0.Q, 0);
      check("rst_dv0", bus0.done_valid, 0);
      check("rst_q1", bus1.Q, 0);
      check("rst_dv1", bus1.done_valid, 0);
      model_reset();
      #1 reset = 1'b0;
   endtask

   initial begin
      int pulses0, pulses1;
      reset = 1'b1;
      s_cv = 0; s_cnt = '0; s_en = 0; s_ab = 0; s_dr = 0;
      drive();
      #1;
      check("init_q", bus0.Q, 0);
      check("init_y", bus0.y, 0);
      check("init_dv", bus0.done_valid, 0);
      check("init_da", bus0.done_aborted, 0);
      check("init_busy", bus0.busy, 0);
      model_reset();
      #2 reset = 1'b0;

      // Load 5 with en held: zero reached on the fifth enabled cycle.
      cycle(1, 5, 1, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0);
      #1;
      check("lat5_q", bus0.Q, 0);
      check("lat5_y", bus0.y, 1);
      check("lat5_dv", bus0.done_valid, 1);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 0, 1);

      // Zero-length run.
      apply_reset();
      cycle(1, 0, 1, 0, 0);
      #1;
      check("zero_dv", bus0.done_valid, 1);
      check("zero_y", bus0.y, 1);
      check("zero_q", bus0.Q, 0);
      check("zero_da", bus0.done_aborted, 0);
      cycle(0, 0, 0, 0, 1);

      // Load 7 with en toggling.
      apply_reset();
      cycle(1, 7, 1, 0, 0);
      for (int i = 0; i < 14; i++) cycle(0, 0, 1'(~i & 1), 0, 0);
      cycle(0, 0, 0, 0, 1);

      // Abort at Q=3, then abort racing the final decrement.
      apply_reset();
      cycle(1, 6, 1, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 1, 0);
      #1;
      check("abt_q", bus0.Q, 3);
      check("abt_da", bus0.done_aborted, 1);
      check("abt_y", bus0.y, 0);
      cycle(0, 0, 0, 0, 1);
      apply_reset();
      cycle(1, 1, 1, 0, 0);
      cycle(0, 0, 1, 1, 0);
      #1;
      check("abt1_q", bus0.Q, 1);
      check("abt1_da", bus0.done_aborted, 1);
      check("abt1_y", bus0.y, 0);
      cycle(0, 0, 0, 0, 1);

      // Done stalled while a command waits.
      apply_reset();
      cycle(1, 2, 1, 0, 0);
      for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 0);
      for (int i = 0; i < 10; i++) cycle(1, 3, 1, 0, 0);
      cycle(1, 3, 1, 0, 1);
      cycle(1, 3, 1, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));

      // Reset mid-run at Q=4.
      apply_reset();
      cycle(1, 6, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
      #1 check("mid_q4", bus0.Q, 4);
      apply_reset();

      // Auto-reload of 2 repeats with done_ready held.
      cycle(1, 2, 1, 0, 1);
      pulses0 = 0;
      pulses1 = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(0, 0, 1, 0, 1);
         #1;
         pulses0 += int'(bus0.y);
         pulses1 += int'(bus1.y);
      end
      check("ar_pulses0", pulses0, 1);
      check("ar_pulses1", pulses1, 4);
      cycle(0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
